axis_stim_gen: RTL and testbench
================================

// Module: axis_stim_gen
// PURPOSE
// Parametrised AXI4-Stream test-pattern source for bring-up and loopback of stream IP/DMA paths.
// Emits packets of programmable length, gap, count and byte-keep, round-robining tdest across NUM_DEST.
// Fully AXIS-compliant: beat payload held stable while tvalid && !tready. Output port is registered.
// PARAMETERS
// TDATA_NUM_BYTES  4     bytes per beat; >=2 (elaboration $fatal otherwise)
// LEN_W            16    width of pkt_len / beat counter
// GAP_W            8     width of gap_cycles
// NUM_DEST         4     tdest channels rotated per packet, 1..16
// FIXED            'h0   upper tdata bits, width TDATA_NUM_BYTES*8-16
// PORTS
// clk              in   1          clock
// rst              in   1          synchronous, active-high reset
// en               in   1          run request (mode-dependent, see BEHAVIOUR)
// clr              in   1          stop request; honoured at next packet boundary
// mode             in   2          0=SINGLE 1=BURST 2=CONT 3=reserved (treated as SINGLE)
// pkt_len          in   LEN_W      beats per packet; 0 treated as 1
// gap_cycles       in   GAP_W      idle cycles (tvalid=0) between packets; 0 = back-to-back
// num_pkts         in   16         packets per BURST; 0 treated as 1
// last_keep        in   TDATA_NUM_BYTES  tkeep on the tlast beat; all-zero treated as all-ones
// M_AXIS_tdata     out  TDATA_NUM_BYTES*8  {FIXED, pkt_seq[7:0], beat[7:0]}
// M_AXIS_tdest     out  4          current channel, 0..NUM_DEST-1
// M_AXIS_tkeep     out  TDATA_NUM_BYTES  all-ones except last beat = last_keep
// M_AXIS_tlast     out  1          high on beat pkt_len-1
// M_AXIS_tready    in   1          downstream ready
// M_AXIS_tvalid    out  1          beat valid
// busy             out  1          high in any state other than IDLE
// pkt_done_cnt     out  32         packets completed since rst (wraps)
// BEHAVIOUR
// - Reset: all outputs 0 (tkeep 0), state IDLE, pkt_seq=0, channel=0, pkt_done_cnt=0.
// - FSM IDLE->LOAD->SEND->GAP->LOAD|IDLE. LOAD is 1 cycle: latches pkt_len, gap, last_keep, mode.
// - Start: en rising edge in IDLE (SINGLE, BURST); en level in IDLE (CONT). Start->first tvalid = 2 clk.
// - SEND: beat advances only on tvalid && tready; beat counts 0..pkt_len-1; tlast on final beat.
// - On tlast accepted: pkt_seq++, channel = (channel==NUM_DEST-1)?0:channel+1, pkt_done_cnt++.
// - After packet: SINGLE->IDLE; BURST->GAP until num_pkts sent, then IDLE; CONT->GAP while en && !clr.
// - GAP counts gap_cycles with tvalid=0; gap=0 goes straight LOAD, so next first beat follows tlast
//   after 1 LOAD cycle (tvalid low exactly 1 clk). Config changes mid-packet take effect at next LOAD.
// - clr or en falling mid-packet: packet completes in full (never truncated), then IDLE; no new packet.
// - clr in GAP/LOAD: IDLE next cycle, tvalid stays 0. clr and start in same cycle: clr wins.
// - Wrap: beat[7:0] and pkt_seq[7:0] wrap modulo 256 in tdata; full-width counters wrap silently.
// - rst mid-packet: tvalid=0 next edge, everything back to reset values; partial packet abandoned.
// - Stall: tdata/tdest/tkeep/tlast/tvalid unchanged while tvalid && !tready; tvalid never withdrawn.
// STRUCTURE
// - Package axis_stim_pkg: typedef enum {ST_IDLE,ST_LOAD,ST_SEND,ST_GAP} stim_state_t;
//   typedef enum logic [1:0] {MODE_SINGLE,MODE_BURST,MODE_CONT} stim_mode_t; MIN_BYTES=2.
// - Single flat module: FSM, beat/gap/packet counters, output register stage with stall hold.
//   No sub-module; en edge detect is a 2-flop shift inline.
// TESTING
// - SINGLE, pkt_len=4, tready=1, en pulse -> 4 beats, tdata low16 0x0000..0x0003, tlast on 4th, busy drops.
// - BURST num_pkts=3, len=2, gap=5, NUM_DEST=2 -> tdest 0,1,0; 5 idle clk between; pkt_done_cnt=3.
// - Random tready (50%) on CONT len=16 -> payload stable under stall, no beat lost/duplicated, seq order.
// - CONT, clr asserted at beat 3 of len=8 -> beats 3..7 still sent with tlast, then tvalid=0, IDLE.
// - pkt_len=0, last_keep=0, 4-byte -> 1-beat packets, tlast=1, tkeep=4'hF every beat.
// - rst at beat 2 of len=8 while tready=0 -> next clk tvalid=0, pkt_done_cnt=0, restart begins beat 0.

Source files
------------

// File: rtl/axis_stim_pkg.sv
// Shared types and constants for the AXI4-Stream test-pattern generator.
package axis_stim_pkg;

  typedef enum logic [1:0] {StIdle, StLoad, StSend, StGap} stim_state_t;

  typedef enum logic [1:0] {ModeSingle, ModeBurst, ModeCont} stim_mode_t;

  localparam int unsigned MinBytes = 2;

  // The reserved encoding behaves as a single-packet request.
  function automatic stim_mode_t decode_mode(input logic [1:0] raw);
    case (raw)
      2'd1:    return ModeBurst;
      2'd2:    return ModeCont;
      default: return ModeSingle;
    endcase
  endfunction

endpackage

// File: rtl/axis_stim_gen.sv
// AXI4-Stream pattern source: packets of programmable length, gap, count and last-beat keep,
// rotating tdest per packet, with a registered output stage that holds payload under stall.
module axis_stim_gen
  import axis_stim_pkg::*;
#(
  parameter int unsigned TDATA_NUM_BYTES = 4,
  parameter int unsigned LEN_W           = 16,
  parameter int unsigned GAP_W           = 8,
  parameter int unsigned NUM_DEST        = 4,
  parameter logic [((TDATA_NUM_BYTES > 2) ? TDATA_NUM_BYTES*8-16 : 1)-1:0] FIXED = '0
) (
  input  logic                         clk,
  input  logic                         rst,
  input  logic                         en,
  input  logic                         clr,
  input  logic [1:0]                   mode,
  input  logic [LEN_W-1:0]             pkt_len,
  input  logic [GAP_W-1:0]             gap_cycles,
  input  logic [15:0]                  num_pkts,
  input  logic [TDATA_NUM_BYTES-1:0]   last_keep,
  output logic [TDATA_NUM_BYTES*8-1:0] M_AXIS_tdata,
  output logic [3:0]                   M_AXIS_tdest,
  output logic [TDATA_NUM_BYTES-1:0]   M_AXIS_tkeep,
  output logic                         M_AXIS_tlast,
  input  logic                         M_AXIS_tready,
  output logic                         M_AXIS_tvalid,
  output logic                         busy,
  output logic [31:0]                  pkt_done_cnt
);

  localparam int unsigned DataW = TDATA_NUM_BYTES * 8;
  // For a 2-byte bus the concatenation is truncated away, leaving no fixed field.
  localparam logic [DataW-1:0] FixedWord = DataW'({FIXED, 16'h0000});
  localparam logic [3:0]       LastDest  = 4'(NUM_DEST - 1);

  if (TDATA_NUM_BYTES < MinBytes) begin : g_bytes_chk
    $fatal(1, "axis_stim_gen: TDATA_NUM_BYTES must be >= %0d", MinBytes);
  end
  if (NUM_DEST < 1 || NUM_DEST > 16) begin : g_dest_chk
    $fatal(1, "axis_stim_gen: NUM_DEST must be in 1..16");
  end

  function automatic logic [DataW-1:0] beat_word(input logic [7:0] seq,
                                                 input logic [LEN_W-1:0] beat);
    return FixedWord | DataW'({seq, 8'(beat)});
  endfunction

  stim_state_t                state_q, state_d;
  stim_mode_t                 mode_q, mode_d;
  logic [1:0]                 en_sr_q, en_sr_d;
  logic [LEN_W-1:0]           len_q, len_d, beat_q, beat_d;
  logic [GAP_W-1:0]           gap_q, gap_d, gap_cnt_q, gap_cnt_d;
  logic [TDATA_NUM_BYTES-1:0] keep_q, keep_d, tkeep_q, tkeep_d;
  logic [15:0]                num_q, num_d, burst_cnt_q, burst_cnt_d;
  logic [7:0]                 seq_q, seq_d;
  logic [3:0]                 chan_q, chan_d;
  logic [31:0]                done_cnt_q, done_cnt_d;
  logic                       stop_q, stop_d;
  logic                       tvalid_q, tvalid_d, tlast_q, tlast_d;
  logic [DataW-1:0]           tdata_q, tdata_d;

  logic        rise, start, accept, pkt_end, cont_halt, stop_now, more, gap_direct;
  logic [15:0] burst_cnt_inc;

  assign rise          = en_sr_q[0] & ~en_sr_q[1];
  assign start         = !clr && ((decode_mode(mode) == ModeCont) ? en_sr_q[0] : rise);
  assign accept        = tvalid_q & M_AXIS_tready;
  assign pkt_end       = (state_q == StSend) & accept & tlast_q;
  assign cont_halt     = (mode_q == ModeCont) & ~en_sr_q[0];
  assign stop_now      = stop_q | clr | cont_halt;
  assign burst_cnt_inc = burst_cnt_q + 16'd1;
  // The LOAD cycle is itself idle, so gaps of 0 and 1 both skip the GAP state.
  assign gap_direct    = (gap_q < GAP_W'(2));

  always_comb begin
    more = 1'b0;
    unique case (mode_q)
      ModeBurst: more = (burst_cnt_inc != num_q);
      ModeCont:  more = 1'b1;
      default:   more = 1'b0;
    endcase
    more = more & ~stop_now;
  end

  // State register.
  always_ff @(posedge clk) begin
    if (rst) state_q <= StIdle;
    else     state_q <= state_d;
  end

  // Next-state logic.
  always_comb begin
    state_d = state_q;
    unique case (state_q)
      StIdle: if (start) state_d = StLoad;
      StLoad: state_d = clr ? StIdle : StSend;
      StSend: begin
        if (pkt_end) begin
          if (!more)          state_d = StIdle;
          else if (gap_direct) state_d = StLoad;
          else                 state_d = StGap;
        end
      end
      StGap: begin
        if (clr || cont_halt)                      state_d = StIdle;
        else if (gap_cnt_q == gap_q - GAP_W'(1)) state_d = StLoad;
      end
      default: state_d = StIdle;
    endcase
  end

  // Datapath and registered output next-state.
  always_comb begin
    en_sr_d     = {en_sr_q[0], en};
    mode_d      = mode_q;
    len_d       = len_q;
    gap_d       = gap_q;
    keep_d      = keep_q;
    num_d       = num_q;
    burst_cnt_d = burst_cnt_q;
    beat_d      = beat_q;
    gap_cnt_d   = gap_cnt_q;
    seq_d       = seq_q;
    chan_d      = chan_q;
    done_cnt_d  = done_cnt_q;
    stop_d      = stop_q;
    tvalid_d    = tvalid_q;
    tdata_d     = tdata_q;
    tkeep_d     = tkeep_q;
    tlast_d     = tlast_q;
    unique case (state_q)
      StIdle: begin
        if (start) begin
          num_d       = (num_pkts == 16'd0) ? 16'd1 : num_pkts;
          burst_cnt_d = 16'd0;
        end
      end
      StLoad: begin
        len_d  = (pkt_len == '0) ? LEN_W'(1) : pkt_len;
        gap_d  = gap_cycles;
        keep_d = (last_keep == '0) ? '1 : last_keep;
        mode_d = decode_mode(mode);
        beat_d = '0;
        stop_d = 1'b0;
        if (!clr) begin
          tvalid_d = 1'b1;
          tdata_d  = beat_word(seq_q, {LEN_W{1'b0}});
          tlast_d  = (len_d == LEN_W'(1));
          tkeep_d  = tlast_d ? keep_d : '1;
        end
      end
      StSend: begin
        stop_d = stop_q | clr;
        if (accept) begin
          if (tlast_q) begin
            tvalid_d    = 1'b0;
            tlast_d     = 1'b0;
            seq_d       = seq_q + 8'd1;
            chan_d      = (chan_q == LastDest) ? 4'd0 : chan_q + 4'd1;
            done_cnt_d  = done_cnt_q + 32'd1;
            burst_cnt_d = burst_cnt_inc;
            gap_cnt_d   = GAP_W'(1);
          end else begin
            beat_d  = beat_q + LEN_W'(1);
            tdata_d = beat_word(seq_q, beat_d);
            tlast_d = (beat_d == len_q - LEN_W'(1));
            tkeep_d = tlast_d ? keep_q : '1;
          end
        end
      end
      StGap: gap_cnt_d = gap_cnt_q + GAP_W'(1);
      default: ;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      en_sr_q     <= 2'b00;
      mode_q      <= ModeSingle;
      len_q       <= LEN_W'(1);
      gap_q       <= '0;
      keep_q      <= '1;
      num_q       <= 16'd1;
      burst_cnt_q <= 16'd0;
      beat_q      <= '0;
      gap_cnt_q   <= '0;
      seq_q       <= 8'd0;
      chan_q      <= 4'd0;
      done_cnt_q  <= 32'd0;
      stop_q      <= 1'b0;
      tvalid_q    <= 1'b0;
      tdata_q     <= '0;
      tkeep_q     <= '0;
      tlast_q     <= 1'b0;
    end else begin
      en_sr_q     <= en_sr_d;
      mode_q      <= mode_d;
      len_q       <= len_d;
      gap_q       <= gap_d;
      keep_q      <= keep_d;
      num_q       <= num_d;
      burst_cnt_q <= burst_cnt_d;
      beat_q      <= beat_d;
      gap_cnt_q   <= gap_cnt_d;
      seq_q       <= seq_d;
      chan_q      <= chan_d;
      done_cnt_q  <= done_cnt_d;
      stop_q      <= stop_d;
      tvalid_q    <= tvalid_d;
      tdata_q     <= tdata_d;
      tkeep_q     <= tkeep_d;
      tlast_q     <= tlast_d;
    end
  end

  assign M_AXIS_tdata  = tdata_q;
  assign M_AXIS_tdest  = chan_q;
  assign M_AXIS_tkeep  = tkeep_q;
  assign M_AXIS_tlast  = tlast_q;
  assign M_AXIS_tvalid = tvalid_q;
  assign busy          = (state_q != StIdle);
  assign pkt_done_cnt  = done_cnt_q;

endmodule

// File: tb/tb_axis_stim_gen.sv
// Directed bench for axis_stim_gen: 4-byte bus, two destinations, fixed upper field 16'hA5C3.
module tb_axis_stim_gen;

  logic        clk = 1'b0;
  logic        rst, en, clr;
  logic [1:0]  mode;
  logic [15:0] pkt_len;
  logic [7:0]  gap_cycles;
  logic [15:0] num_pkts;
  logic [3:0]  last_keep;
  logic [31:0] M_AXIS_tdata;
  logic [3:0]  M_AXIS_tdest;
  logic [3:0]  M_AXIS_tkeep;
  logic        M_AXIS_tlast, M_AXIS_tready, M_AXIS_tvalid, busy;
  logic [31:0] pkt_done_cnt;

  int n_checks = 0;
  int n_errors = 0;
  int cyc = 0;
  int acc_cyc[$];
  int cur_len;
  logic [3:0] cur_keep;

  axis_stim_gen #(
    .TDATA_NUM_BYTES(4),
    .LEN_W(16),
    .GAP_W(8),
    .NUM_DEST(2),
    .FIXED(16'hA5C3)
  ) u_dut (
    .clk(clk),
    .rst(rst),
    .en(en),
    .clr(clr),
    .mode(mode),
    .pkt_len(pkt_len),
    .gap_cycles(gap_cycles),
    .num_pkts(num_pkts),
    .last_keep(last_keep),
    .M_AXIS_tdata(M_AXIS_tdata),
    .M_AXIS_tdest(M_AXIS_tdest),
    .M_AXIS_tkeep(M_AXIS_tkeep),
    .M_AXIS_tlast(M_AXIS_tlast),
    .M_AXIS_tready(M_AXIS_tready),
    .M_AXIS_tvalid(M_AXIS_tvalid),
    .busy(busy),
    .pkt_done_cnt(pkt_done_cnt)
  );

  always #5 clk = ~clk;

  task automatic check_eq(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_errors++;
      $display("FAIL %s: got 0x%0h expected 0x%0h (cycle %0d)", tag, got, exp, cyc);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
    cyc++;
  endtask

  task automatic do_reset();
    rst = 1'b1;
    en  = 1'b0;
    clr = 1'b0;
    tick();
    tick();
    rst = 1'b0;
  endtask

  // Expected beat k of a stream that started at packet 0 after reset.
  function automatic logic [31:0] exp_data(input int k);
    logic [7:0] p, b;
    p = 8'(k / cur_len);
    b = 8'(k % cur_len);
    return {16'hA5C3, p, b};
  endfunction

  function automatic logic exp_last(input int k);
    return (k % cur_len) == cur_len - 1;
  endfunction

  // Every presented beat must equal the next model beat, so a stalled beat is checked each cycle.
  task automatic run_stream(input int base, input int n, input int max_cyc, input bit rnd);
    int  acc = 0;
    int  waited = 0;
    bit  prev_stall = 1'b0;
    int  k;
    acc_cyc.delete();
    while (acc < n && waited < max_cyc) begin
      M_AXIS_tready = rnd ? 1'($urandom_range(0, 1)) : 1'b1;
      if (prev_stall) check_eq("tvalid_held", 64'(M_AXIS_tvalid), 64'd1);
      if (M_AXIS_tvalid) begin
        k = base + acc;
        check_eq("tdata", 64'(M_AXIS_tdata), 64'(exp_data(k)));
        check_eq("tlast", 64'(M_AXIS_tlast), 64'(exp_last(k)));
        check_eq("tkeep", 64'(M_AXIS_tkeep), 64'(exp_last(k) ? cur_keep : 4'hF));
        check_eq("tdest", 64'(M_AXIS_tdest), 64'((k / cur_len) % 2));
        if (M_AXIS_tready) begin
          acc_cyc.push_back(cyc);
          acc++;
        end
      end
      prev_stall = M_AXIS_tvalid && !M_AXIS_tready;
      tick();
      waited++;
    end
    check_eq("stream_beats", 64'(acc), 64'(n));
    M_AXIS_tready = 1'b1;
  endtask

  task automatic wait_idle(input int max_cyc);
    for (int i = 0; i < max_cyc && busy; i++) tick();
    check_eq("idle_busy", 64'(busy), 64'd0);
    check_eq("idle_tvalid", 64'(M_AXIS_tvalid), 64'd0);
  endtask

  initial begin
    #2000000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    mode = 2'd0; pkt_len = 16'd4; gap_cycles = 8'd0; num_pkts = 16'd1; last_keep = 4'h3;
    M_AXIS_tready = 1'b1;
    do_reset();

    check_eq("rst_tvalid", 64'(M_AXIS_tvalid), 64'd0);
    check_eq("rst_tdata", 64'(M_AXIS_tdata), 64'd0);
    check_eq("rst_tkeep", 64'(M_AXIS_tkeep), 64'd0);
    check_eq("rst_tlast", 64'(M_AXIS_tlast), 64'd0);
    check_eq("rst_tdest", 64'(M_AXIS_tdest), 64'd0);
    check_eq("rst_busy", 64'(busy), 64'd0);
    check_eq("rst_done", 64'(pkt_done_cnt), 64'd0);

    // SINGLE, 4 beats, last_keep 3: two clocks from sampled en to first tvalid.
    cur_len = 4; cur_keep = 4'h3;
    en = 1'b1;
    tick();
    en = 1'b0;
    tick();
    check_eq("single_lat1_tvalid", 64'(M_AXIS_tvalid), 64'd0);
    check_eq("single_lat1_busy", 64'(busy), 64'd1);
    tick();
    check_eq("single_lat2_tvalid", 64'(M_AXIS_tvalid), 64'd1);
    run_stream(0, 4, 20, 1'b0);
    check_eq("single_end_busy", 64'(busy), 64'd0);
    check_eq("single_end_tvalid", 64'(M_AXIS_tvalid), 64'd0);
    check_eq("single_done", 64'(pkt_done_cnt), 64'd1);
    check_eq("single_next_dest", 64'(M_AXIS_tdest), 64'd1);
    repeat (3) tick();
    check_eq("single_no_restart", 64'(M_AXIS_tvalid), 64'd0);

    // BURST of 3 two-beat packets, gap 5.
    do_reset();
    mode = 2'd1; num_pkts = 16'd3; pkt_len = 16'd2; gap_cycles = 8'd5; last_keep = 4'hC;
    cur_len = 2; cur_keep = 4'hC;
    en = 1'b1;
    tick();
    en = 1'b0;
    run_stream(0, 6, 100, 1'b0);
    if (acc_cyc.size() == 6) begin
      check_eq("burst_b2b", 64'(acc_cyc[1] - acc_cyc[0]), 64'd1);
      check_eq("burst_gap1", 64'(acc_cyc[2] - acc_cyc[1] - 1), 64'd5);
      check_eq("burst_gap2", 64'(acc_cyc[4] - acc_cyc[3] - 1), 64'd5);
    end
    check_eq("burst_done", 64'(pkt_done_cnt), 64'd3);
    check_eq("burst_end_busy", 64'(busy), 64'd0);
    repeat (8) tick();
    check_eq("burst_no_fourth", 64'(pkt_done_cnt), 64'd3);

    // CONT, len 16, random backpressure, three packets, then clr at the boundary.
    do_reset();
    mode = 2'd2; pkt_len = 16'd16; gap_cycles = 8'd0; last_keep = 4'h0;
    cur_len = 16; cur_keep = 4'hF;
    en = 1'b1;
    run_stream(0, 48, 2000, 1'b1);
    clr = 1'b1;
    en  = 1'b0;
    wait_idle(20);
    check_eq("cont_rand_done", 64'(pkt_done_cnt), 64'd3);
    clr = 1'b0;

    // CONT, len 8, clr raised when beat 3 is presented: packet still completes.
    do_reset();
    mode = 2'd2; pkt_len = 16'd8; gap_cycles = 8'd0; last_keep = 4'h7;
    cur_len = 8; cur_keep = 4'h7;
    en = 1'b1;
    run_stream(0, 3, 20, 1'b0);
    clr = 1'b1;
    run_stream(3, 5, 20, 1'b0);
    check_eq("clr_tvalid", 64'(M_AXIS_tvalid), 64'd0);
    check_eq("clr_busy", 64'(busy), 64'd0);
    check_eq("clr_done", 64'(pkt_done_cnt), 64'd1);
    repeat (3) tick();
    check_eq("clr_stays_idle", 64'(M_AXIS_tvalid), 64'd0);
    en  = 1'b0;
    clr = 1'b0;

    // pkt_len 0 and last_keep 0: single-beat packets, one idle clock between them.
    do_reset();
    mode = 2'd2; pkt_len = 16'd0; gap_cycles = 8'd0; last_keep = 4'h0;
    cur_len = 1; cur_keep = 4'hF;
    en = 1'b1;
    run_stream(0, 4, 40, 1'b0);
    if (acc_cyc.size() == 4) begin
      check_eq("len0_gap_a", 64'(acc_cyc[1] - acc_cyc[0]), 64'd2);
      check_eq("len0_gap_b", 64'(acc_cyc[3] - acc_cyc[2]), 64'd2);
    end
    en = 1'b0;
    wait_idle(20);
    check_eq("len0_done", 64'(pkt_done_cnt), 64'd5);

    // Reset during a stalled beat, then a clean restart from beat 0.
    do_reset();
    mode = 2'd2; pkt_len = 16'd8; gap_cycles = 8'd0; last_keep = 4'hF;
    cur_len = 8; cur_keep = 4'hF;
    en = 1'b1;
    run_stream(0, 10, 60, 1'b0);
    check_eq("pre_rst_done", 64'(pkt_done_cnt), 64'd1);
    M_AXIS_tready = 1'b0;
    tick();
    check_eq("stall_tvalid", 64'(M_AXIS_tvalid), 64'd1);
    check_eq("stall_tdata", 64'(M_AXIS_tdata), 64'h0000_0000_A5C3_0102);
    rst = 1'b1;
    tick();
    check_eq("rst_mid_tvalid", 64'(M_AXIS_tvalid), 64'd0);
    check_eq("rst_mid_done", 64'(pkt_done_cnt), 64'd0);
    check_eq("rst_mid_tkeep", 64'(M_AXIS_tkeep), 64'd0);
    check_eq("rst_mid_busy", 64'(busy), 64'd0);
    rst = 1'b0;
    M_AXIS_tready = 1'b1;
    run_stream(0, 1, 20, 1'b0);
    en = 1'b0;
    wait_idle(30);

    $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
    $finish;
  end

endmodule
